usb_phy_tx: RTL

Parametrised USB transmit serializer: the next generation of the transceiver's TX path. It accepts 8- or 16-bit words over a valid/ready handshake and drives SYNC, data, bit stuffing and EOP onto D+/D- with NRZI encoding. Bit rate is set by a clock-divide parameter, so one block serves both full-speed and low-speed ports. It sits between the protocol engine's TX interface and the bidirectional USB pads.

---
 rtl/usb_phy_tx.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/usb_phy_tx.sv
// usb_phy_tx: USB transmit serializer (SYNC, NRZI, bit stuffing, EOP) with a
// configurable bit period. Define USB_TX_ABORT_EN to add the tx_abort path.
module usb_phy_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int BIT_CYCLES = 2,
  parameter bit LOW_SPEED  = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  output logic [1:0]            d_o,
  output logic                  d_en,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  valid,
  input  logic                  valid_h,
  output logic                  ready,
  output logic                  tx_active
`ifdef USB_TX_ABORT_EN
  ,
  input  logic                  tx_abort
`endif
);

  localparam int CW = (BIT_CYCLES > 2) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CYCLES - 1);
  localparam logic [1:0] LINE_J   = LOW_SPEED ? 2'b01 : 2'b10;
  localparam logic [1:0] LINE_K   = LOW_SPEED ? 2'b10 : 2'b01;
  localparam logic [1:0] LINE_SE0 = 2'b00;

`ifdef USB_TX_ABORT_EN
  typedef enum logic [2:0] {IDLE, SYNC, DATA, STUFF, EOP_SE0, EOP_J, ABORT} state_t;
  logic abort_req, abort_n;
`else
  typedef enum logic [2:0] {IDLE, SYNC, DATA, STUFF, EOP_SE0, EOP_J} state_t;
`endif

  state_t                  state, state_n;
  logic [CW-1:0]           cnt, cnt_n;
  logic [2:0]              bcnt, bcnt_n;
  logic [2:0]              ones, ones_n;
  logic [4:0]              left, left_n;
  logic [DATA_WIDTH-1:0]   shreg, shreg_n;
  logic [1:0]              line_n;
  logic                    den_n, ready_n, strobe, send, bit_v;

  function automatic logic [1:0] nrzi_toggle(input logic [1:0] l);
    return (l == LINE_J) ? LINE_K : LINE_J;
  endfunction

  assign strobe = (cnt == CNT_LAST);

  always_comb begin
    state_n = state;
    line_n  = d_o;
    den_n   = d_en;
    ready_n = 1'b0;
    cnt_n   = strobe ? '0 : cnt + 1'b1;
    bcnt_n  = bcnt;
    ones_n  = ones;
    left_n  = left;
    shreg_n = shreg;
    send    = 1'b0;
    bit_v   = 1'b0;
`ifdef USB_TX_ABORT_EN
    abort_n = abort_req | (tx_abort && (state == SYNC || state == DATA));
`endif
    case (state)
      IDLE: begin
        cnt_n  = '0;
        line_n = LINE_J;
        den_n  = 1'b0;
        bcnt_n = 3'd0;
        ones_n = 3'd0;
        left_n = 5'd0;
`ifdef USB_TX_ABORT_EN
        abort_n = 1'b0;
`endif
        if (valid) begin
          state_n = SYNC;
          line_n  = LINE_K;
          den_n   = 1'b1;
        end
      end
      SYNC, DATA, STUFF: if (strobe) begin
`ifdef USB_TX_ABORT_EN
        if (abort_n) begin
          state_n = ABORT;
          bcnt_n  = 3'd0;
          abort_n = 1'b0;
        end else
`endif
        if (state == SYNC && bcnt != 3'd7) begin
          // SYNC is seven 0s then a 1; that final 1 seeds the stuffing count
          bcnt_n = bcnt + 3'd1;
          if (bcnt == 3'd6) ones_n = 3'd1;
          else              line_n = nrzi_toggle(d_o);
        end else if (ones == 3'd6) begin
          state_n = STUFF;
          line_n  = nrzi_toggle(d_o);
          ones_n  = 3'd0;
        end else if (left != 5'd0) begin
          state_n = DATA;
          send    = 1'b1;
          bit_v   = shreg[0];
          shreg_n = shreg >> 1;
          left_n  = left - 5'd1;
        end else if (valid) begin
          state_n = DATA;
          ready_n = 1'b1;
          send    = 1'b1;
          bit_v   = data[0];
          shreg_n = data >> 1;
          left_n  = (DATA_WIDTH == 16 && valid_h) ? 5'd15 : 5'd7;
        end else begin
          state_n = EOP_SE0;
          line_n  = LINE_SE0;
          bcnt_n  = 3'd0;
        end
      end
      EOP_SE0: if (strobe) begin
        if (bcnt == 3'd1) begin
          state_n = EOP_J;
          line_n  = LINE_J;
        end else begin
          bcnt_n = bcnt + 3'd1;
        end
      end
      EOP_J: if (strobe) begin
        state_n = IDLE;
        den_n   = 1'b0;
        line_n  = LINE_J;
      end
`ifdef USB_TX_ABORT_EN
      // Seven held bit periods: an intentional stuffing violation
      ABORT: if (strobe) begin
        if (bcnt == 3'd6) begin
          state_n = EOP_SE0;
          line_n  = LINE_SE0;
          bcnt_n  = 3'd0;
        end else begin
          bcnt_n = bcnt + 3'd1;
        end
      end
`endif
      default: state_n = IDLE;
    endcase
    if (send) begin
      line_n = bit_v ? d_o : nrzi_toggle(d_o);
      ones_n = bit_v ? ones + 3'd1 : 3'd0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      bcnt      <= 3'd0;
      ones      <= 3'd0;
      left      <= 5'd0;
      d_o       <= LINE_J;
      d_en      <= 1'b0;
      ready     <= 1'b0;
      tx_active <= 1'b0;
`ifdef USB_TX_ABORT_EN
      abort_req <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      bcnt      <= bcnt_n;
      ones      <= ones_n;
      left      <= left_n;
      d_o       <= line_n;
      d_en      <= den_n;
      ready     <= ready_n;
      tx_active <= den_n;
`ifdef USB_TX_ABORT_EN
      abort_req <= abort_n;
`endif
    end
  end

  always_ff @(posedge clk) begin
    shreg <= shreg_n;
  end

endmodule
